// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the fetch PC generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0080;

    function automatic int btb_idx_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
// Latency: lookup 0 cycles; update visible to lookups from the next cycle.
// Backpressure: none; updates always accepted, clear beats update.
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            hit,
    output logic [PC_W-1:0] hit_tgt,
    input  logic            upd_vld,
    input  logic            clr,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_tgt
);

    localparam int IDX_W = btb_idx_w(DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;

    logic [DEPTH-1:0] vld;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PC_W-1:0]  tgt_mem [DEPTH];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    assign rd_idx = lookup_pc[IDX_W+1:2];
    assign wr_idx = upd_pc[IDX_W+1:2];

    // Only valid bits need reset; tag/target are qualified by them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld <= '0;
        end else if (clr) begin
            vld <= '0;
        end else if (upd_vld) begin
            vld[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (upd_vld && !clr) begin
            tag_mem[wr_idx] <= upd_pc[PC_W-1:IDX_W+2];
            tgt_mem[wr_idx] <= upd_tgt;
        end
    end

    assign hit     = vld[rd_idx] && (tag_mem[rd_idx] == lookup_pc[PC_W-1:IDX_W+2]);
    assign hit_tgt = tgt_mem[rd_idx];

    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with BOOT/RUN/HALT control; BTB built only with PC_GEN_BTB_EN.
// Latency: every next-PC source lands on o_pc one cycle after the sampling edge.
// Backpressure: i_pc_write=0 holds the PC; exception/redirect override the stall.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(DEF_EXC_VEC),
    parameter int              INC       = 4,
    parameter int              BTB_DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_pc_write,
    input  logic            i_redirect,
    input  logic [PC_W-1:0] i_redirect_pc,
    input  logic            i_exc,
    input  logic            i_halt,
    input  logic            i_btb_upd,
    input  logic            i_btb_clr,
    input  logic [PC_W-1:0] i_btb_upd_pc,
    input  logic [PC_W-1:0] i_btb_upd_tgt,
    output logic [PC_W-1:0] o_pc,
    output logic            o_pc_valid,
    output logic            o_pred_taken
);

    pc_state_e       state;
    pc_state_e       nxt_state;
    logic [PC_W-1:0] nxt_pc;
    logic            adv;
    logic            btb_hit;
    logic [PC_W-1:0] btb_tgt;

`ifdef PC_GEN_BTB_EN
    pc_btb #(
        .PC_W  (PC_W),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .lookup_pc (o_pc),
        .hit       (btb_hit),
        .hit_tgt   (btb_tgt),
        .upd_vld   (i_btb_upd),
        .clr       (i_btb_clr),
        .upd_pc    (i_btb_upd_pc),
        .upd_tgt   (i_btb_upd_tgt)
    );
`else
    assign btb_hit = 1'b0;
    assign btb_tgt = '0;

    logic unused_btb_in;
    assign unused_btb_in = ^{i_btb_upd, i_btb_clr, i_btb_upd_pc, i_btb_upd_tgt};
`endif

    always_comb begin
        nxt_state = state;
        nxt_pc    = o_pc;
        adv       = 1'b0;
        if (i_exc) begin
            nxt_pc    = EXC_VEC;
            nxt_state = ST_RUN;
        end else if (i_redirect) begin
            nxt_pc    = i_redirect_pc;
            nxt_state = ST_RUN;
        end else begin
            case (state)
                ST_BOOT: nxt_state = ST_RUN;
                ST_RUN: begin
                    if (i_halt) begin
                        nxt_state = ST_HALT;
                    end else if (i_pc_write) begin
                        adv    = 1'b1;
                        nxt_pc = btb_hit ? btb_tgt : o_pc + PC_W'(INC);
                    end
                end
                default: nxt_state = state;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_BOOT;
            o_pc  <= RESET_VEC;
        end else begin
            state <= nxt_state;
            o_pc  <= nxt_pc;
        end
    end

    assign o_pc_valid = (state == ST_RUN);

`ifdef PC_GEN_BTB_EN
    // Prediction flag follows the PC: it is held while the PC is held.
    logic pred_q;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pred_q <= 1'b0;
        end else if (i_exc || i_redirect) begin
            pred_q <= 1'b0;
        end else if (adv) begin
            pred_q <= btb_hit;
        end
    end
    assign o_pred_taken = pred_q;
`else
    assign o_pred_taken = 1'b0;
`endif

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter PC_W, 32, PC width in bits.
REQ-002 Parameter RESET_VEC, 32'h0000_0000, PC value loaded on reset.
REQ-003 Parameter EXC_VEC, 32'h0000_0080, PC value loaded on exception.
REQ-004 Parameter INC, 4, sequential increment in bytes.
REQ-005 Parameter BTB_DEPTH, 8, BTB entry count, power of two, >= 2.
REQ-006 i_clk  input  1  clock; all state updates on rising edge.
REQ-007 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-008 i_pc_write  input  1  1 = PC may advance; 0 = hazard stall.
REQ-009 i_redirect  input  1  branch/jump resolved in EX; load i_redirect_pc.
REQ-010 i_redirect_pc  input  PC_W  redirect target.
REQ-011 i_exc  input  1  exception request; load EXC_VEC.
REQ-012 i_halt  input  1  halt instruction decoded; freeze PC.
REQ-013 i_btb_upd, i_btb_clr  input  1 each  BTB write / invalidate strobe.
REQ-014 i_btb_upd_pc, i_btb_upd_tgt  input  PC_W each  BTB update branch PC and target.
REQ-015 o_pc  output  PC_W  current fetch PC.
REQ-016 o_pc_valid  output  1  o_pc is a real fetch address.
REQ-017 o_pred_taken  output  1  next PC taken from a BTB hit.

Function
REQ-018 FSM states BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-019 o_pc_valid SHALL be 0 in BOOT and HALT and 1 in RUN.
REQ-020 Next-PC priority: i_exc > i_redirect > HALT state / i_pc_write=0 (hold) > BTB hit > o_pc+INC.
REQ-021 i_exc or i_redirect SHALL load the PC even when i_pc_write=0, and SHALL move HALT or BOOT to RUN.
REQ-022 i_halt in RUN with no i_exc/i_redirect SHALL enter HALT and hold o_pc; HALT persists until i_exc or i_redirect.
REQ-023 Sequential increment wraps modulo 2^PC_W; all-ones minus (INC-1) + INC = 0.
REQ-024 Latency: a load of any next-PC source appears on o_pc one cycle after the sampling edge.
REQ-025 o_pred_taken is registered alongside o_pc; it is 1 only when the current o_pc came from a BTB hit.
REQ-026 BTB index = pc[log2(BTB_DEPTH)+1:2], tag = remaining upper bits; a hit needs valid and tag match.
REQ-027 i_btb_upd writes valid, tag, and target at the index of i_btb_upd_pc; i_btb_clr clears all valid bits; when both are asserted, clr wins.
REQ-028 A BTB lookup in the same cycle as a write to the same index SHALL see the old contents.

Reset
REQ-029 Asynchronous assertion: o_pc=RESET_VEC, state=BOOT, o_pc_valid=0, o_pred_taken=0, all BTB valid bits=0.
REQ-030 Reset mid-operation (any state, pending redirect) SHALL discard all pending requests.

Configuration
REQ-031 Macro PC_GEN_BTB_EN: when defined, the BTB of REQ-026..028 is built.
REQ-032 Without PC_GEN_BTB_EN: no BTB storage is built, o_pred_taken is tied to 0, and BTB inputs are ignored.

Structure
REQ-033 Package pc_gen_pkg SHALL hold the state enum (BOOT/RUN/HALT) and the default RESET_VEC/EXC_VEC constants.
REQ-034 Sub-module pc_btb (lookup + update storage) SHALL be instantiated only under PC_GEN_BTB_EN.

Verification
REQ-035 Reset, release, and 3 cycles with i_pc_write=1: o_pc 0,0,4,8 and o_pc_valid 0,1,1,1.
REQ-036 i_pc_write=0 for 2 cycles at PC 0x10, then i_redirect=1 with target 0x200 while still stalled: PC 0x10 held, then 0x200.
REQ-037 i_exc and i_redirect in the same cycle (target 0x300): o_pc=0x80 next cycle.
REQ-038 i_halt at PC 0x20: o_pc stays 0x20 and o_pc_valid=0 for 5 cycles; i_redirect to 0x40 returns to RUN with o_pc=0x40.
REQ-039 PC_W=8, PC=0xFC, INC=4: next o_pc=0x00.
REQ-040 BTB enabled: update at 0x8 with target 0x100, run from 0: o_pc 0,4,8,0x100 with o_pred_taken=1 at 0x100; after i_btb_clr, sequence is 0,4,8,0xC.
